// File: rtl/sdram_resp_pkg.sv
// Shared types and defaults for the SDRAM request responder: FSM states,
// client index type and default address/data widths.
package sdram_resp_pkg;

  localparam int unsigned ADDR_W_DEF      = 23;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RWAIT = 2'd2,
    ACK   = 2'd3
  } state_t;

  // Client index: 0 = mixing core, 1 = recorder/player.
  typedef logic client_t;

  localparam client_t CLIENT0 = 1'b0;
  localparam client_t CLIENT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter. The preferred-client pointer moves to the
// other client whenever a grant is taken (i_update with a valid request).
module rr_arbiter2
  import sdram_resp_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_valid,
  output client_t    o_gnt
);

  client_t r_pref;

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    o_valid = |i_req;
    o_gnt   = client_t'(i_req[1]);
    if (&i_req) begin
      o_gnt = r_pref;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pref <= CLIENT0;
    end else if (i_update && o_valid) begin
      r_pref <= ~o_gnt;
    end
  end

endmodule

// File: rtl/sdram_req_responder.sv
// Responder for the level-held SDRAM request protocol: arbitrates two clients
// and runs one Avalon-MM transaction at a time. Optional watchdog: SDRAM_RESP_TIMEOUT_EN.
module sdram_req_responder
  import sdram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              c0_read,
  input  logic              c0_write,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_writedata,
  output logic [DATA_W-1:0] c0_readdata,
  output logic              c0_finished,
  input  logic              c1_read,
  input  logic              c1_write,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_writedata,
  output logic [DATA_W-1:0] c1_readdata,
  output logic              c1_finished,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic              o_timeout
);

  state_t            r_state;
  client_t           r_gnt;
  logic              r_is_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_avm_read;
  logic              r_avm_write;
  logic [1:0]        r_fin;
  logic [DATA_W-1:0] r_rdata [2];
  logic              r_timeout;

  logic [1:0]        w_req;
  logic              w_gnt_valid;
  client_t           w_gnt;
  logic              w_tmo;

  assign w_req = {c1_read | c1_write, c0_read | c0_write};

  rr_arbiter2 u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    (w_req),
    .i_update (r_state == IDLE),
    .o_valid  (w_gnt_valid),
    .o_gnt    (w_gnt)
  );

`ifdef SDRAM_RESP_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] r_tmo_cnt;

  // Counts wait cycles of the current command; fires on the last allowed cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == CMD || r_state == RWAIT) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_tmo = (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_gnt       <= CLIENT0;
      r_is_wr     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_avm_read  <= 1'b0;
      r_avm_write <= 1'b0;
      r_fin       <= 2'b00;
      r_rdata[0]  <= '0;
      r_rdata[1]  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_fin <= 2'b00;
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            // Read+write together counts as a write.
            r_gnt       <= w_gnt;
            r_is_wr     <= w_gnt ? c1_write : c0_write;
            r_addr      <= w_gnt ? c1_addr : c0_addr;
            r_wdata     <= w_gnt ? c1_writedata : c0_writedata;
            r_avm_write <= w_gnt ? c1_write : c0_write;
            r_avm_read  <= w_gnt ? ~c1_write : ~c0_write;
            r_state     <= CMD;
          end
        end
        CMD: begin
          if (!avm_waitrequest) begin
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
            if (r_is_wr) begin
              r_fin[r_gnt] <= 1'b1;
              r_state      <= ACK;
            end else if (avm_readdatavalid) begin
              r_rdata[r_gnt] <= avm_readdata;
              r_fin[r_gnt]   <= 1'b1;
              r_state        <= ACK;
            end else begin
              r_state <= RWAIT;
            end
          end else if (w_tmo) begin
            r_avm_read     <= 1'b0;
            r_avm_write    <= 1'b0;
            r_rdata[r_gnt] <= '0;
            r_fin[r_gnt]   <= 1'b1;
            r_timeout      <= 1'b1;
            r_state        <= ACK;
          end
        end
        RWAIT: begin
          if (avm_readdatavalid) begin
            r_rdata[r_gnt] <= avm_readdata;
            r_fin[r_gnt]   <= 1'b1;
            r_state        <= ACK;
          end else if (w_tmo) begin
            r_rdata[r_gnt] <= '0;
            r_fin[r_gnt]   <= 1'b1;
            r_timeout      <= 1'b1;
            r_state        <= ACK;
          end
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign avm_address   = r_addr;
  assign avm_writedata = r_wdata;
  assign avm_read      = r_avm_read;
  assign avm_write     = r_avm_write;
  assign c0_finished   = r_fin[0];
  assign c1_finished   = r_fin[1];
  assign c0_readdata   = r_rdata[0];
  assign c1_readdata   = r_rdata[1];
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_sdram_req_responder.sv
// Self-checking bench for sdram_req_responder: directed scenarios plus a
// randomized two-client run scored against a transaction-level reference model.
module tb_sdram_req_responder;

  localparam int AW  = 23;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_rd   [2];
  logic          req_wr   [2];
  logic [AW-1:0] req_addr [2];
  logic [DW-1:0] req_data [2];

  logic [DW-1:0] c0_readdata, c1_readdata;
  logic          c0_finished, c1_finished;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [DW-1:0] avm_writedata;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid, avm_waitrequest;
  logic          o_timeout;
  logic [1:0]    fin;

  assign fin = {c1_finished, c0_finished};

  sdram_req_responder #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .c0_read           (req_rd[0]),
    .c0_write          (req_wr[0]),
    .c0_addr           (req_addr[0]),
    .c0_writedata      (req_data[0]),
    .c0_readdata       (c0_readdata),
    .c0_finished       (c0_finished),
    .c1_read           (req_rd[1]),
    .c1_write          (req_wr[1]),
    .c1_addr           (req_addr[1]),
    .c1_writedata      (req_data[1]),
    .c1_readdata       (c1_readdata),
    .c1_finished       (c1_finished),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest),
    .o_timeout         (o_timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state: memory, arbitration history, expected completions.
  typedef struct packed {
    logic          cl;
    logic          rd;
    logic [DW-1:0] data;
  } exp_t;

  logic [DW-1:0] mem [int];
  exp_t          exp_q [$];
  int            grant_log [$];
  logic [AW-1:0] addr_log [$];
  int            rq_due [$];
  logic [DW-1:0] rq_data [$];
  int            last_g = 1;
  int            cur_g  = 0;
  int            cyc    = 0;
  int            fin_cnt = 0;

  int  cfg_wait = 0, cfg_lat = 0;
  bit  cfg_rand = 0, cfg_stuck = 0, sb_en = 0;
  int  last_len = 0;
  bit  last_stable = 0;

  bit            snap_req  [2];
  bit            snap_wr   [2];
  logic [AW-1:0] snap_addr [2];
  logic [DW-1:0] snap_data [2];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : '0;
  endfunction

  // Round robin: with both requesting, the one not served last wins.
  function automatic int exp_grant(input bit r0, input bit r1, input int last);
    if (r0 && r1) return (last == 0) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Avalon slave: configurable stall and read latency, backed by mem.
  initial begin : slave
    bit            cmd_active = 0;
    bit            stable_ok;
    int            wait_left = 0, cmd_len = 0, lat;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          cmd_wr;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      if (avm_read || avm_write) begin
        if (!cmd_active) begin
          cmd_active = 1;
          cmd_len    = 0;
          stable_ok  = 1;
          cmd_addr   = avm_address;
          cmd_data   = avm_writedata;
          cmd_wr     = avm_write;
          wait_left  = cfg_stuck ? 1000000 : (cfg_rand ? int'($urandom_range(3, 0)) : cfg_wait);
          if (sb_en) begin
            cur_g = exp_grant(snap_req[0], snap_req[1], last_g);
            check("cmd_has_req", 64'(snap_req[0] | snap_req[1]), 64'd1);
            check("cmd_addr", 64'(avm_address), 64'(snap_addr[cur_g]));
            check("cmd_write", 64'(avm_write), 64'(snap_wr[cur_g]));
            check("cmd_read", 64'(avm_read), 64'(!snap_wr[cur_g]));
            if (snap_wr[cur_g]) check("cmd_wdata", 64'(avm_writedata), 64'(snap_data[cur_g]));
            last_g = cur_g;
            grant_log.push_back(cur_g);
          end
        end else if (avm_address !== cmd_addr || avm_writedata !== cmd_data || avm_write !== cmd_wr) begin
          stable_ok = 0;
        end
        cmd_len++;
        if (wait_left > 0) begin
          avm_waitrequest = 1'b1;
          wait_left--;
        end else begin
          avm_waitrequest = 1'b0;
          cmd_active      = 0;
          last_len        = cmd_len;
          last_stable     = stable_ok;
          addr_log.push_back(cmd_addr);
          if (cmd_wr) begin
            mem[int'(cmd_addr)] = cmd_data;
            if (sb_en) exp_q.push_back('{cl: 1'(cur_g), rd: 1'b0, data: '0});
          end else begin
            lat = cfg_rand ? int'($urandom_range(3, 0)) : cfg_lat;
            rq_due.push_back(cyc + lat);
            rq_data.push_back(mem_rd(cmd_addr));
            if (sb_en) exp_q.push_back('{cl: 1'(cur_g), rd: 1'b1, data: mem_rd(cmd_addr)});
          end
        end
      end else begin
        cmd_active      = 0;
        avm_waitrequest = cfg_stuck ? 1'b1 : 1'($urandom() & 1);
      end
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rq_data.pop_front();
        void'(rq_due.pop_front());
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom();
      end
    end
  end

  // Completion monitor and request snapshot, both on the falling edge.
  initial forever begin : monitor
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      snap_req[k]  = req_rd[k] | req_wr[k];
      snap_wr[k]   = req_wr[k];
      snap_addr[k] = req_addr[k];
      snap_data[k] = req_data[k];
    end
    if (fin != 2'b00) begin
      fin_cnt++;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          check("fin_spurious", 64'(fin), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("fin_client", 64'(fin), e.cl ? 64'd2 : 64'd1);
          if (e.rd) check("rdata", 64'(e.cl ? c1_readdata : c0_readdata), 64'(e.data));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drop(input int k);
    req_rd[k] = 1'b0;
    req_wr[k] = 1'b0;
  endtask

  // Present one held request, wait for finished; returns cycles from the
  // sampling cycle to the finished cycle. Ends just after the next rising edge.
  task automatic client_op(input int k, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output int lat);
    int start;
    bit got;
    req_rd[k]   = rd;
    req_wr[k]   = wr;
    req_addr[k] = a;
    req_data[k] = d;
    start = cyc;
    got   = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (fin[k]) got = 1;
    end
    lat = cyc - start;
    check($sformatf("fin_seen_c%0d", k), 64'(got), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst    = 1'b0;
    last_g = 1;
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int lat, fc, start;
    bit got;
    for (int k = 0; k < 2; k++) begin
      req_rd[k] = 0; req_wr[k] = 0; req_addr[k] = '0; req_data[k] = '0;
    end
    #12;
    check("rst_avm_read", 64'(avm_read), 64'd0);
    check("rst_avm_write", 64'(avm_write), 64'd0);
    check("rst_finished", 64'(fin), 64'd0);
    check("rst_readdata", 64'({c1_readdata, c0_readdata}), 64'd0);
    check("rst_address", 64'(avm_address), 64'd0);
    check("rst_timeout", 64'(o_timeout), 64'd0);
    idle(1);
    rst = 1'b0;

    // Single read, latency 2: finished L+2 cycles after sampling (L+3 counting the sample cycle).
    sb_en = 1; cfg_lat = 2; cfg_wait = 0;
    mem[32'h100] = 32'h1234ABCD;
    fc = fin_cnt;
    client_op(0, 1, 0, 23'h000100, '0, lat);
    drop(0);
    check("t1_latency", 64'(lat), 64'd4);
    check("t1_rdata", 64'(c0_readdata), 64'h1234ABCD);
    idle(3);
    check("t1_fin_count", 64'(fin_cnt - fc), 64'd1);

    // Write stalled 5 cycles: command held 6 cycles, finished the cycle after acceptance.
    cfg_wait = 5;
    client_op(1, 0, 1, 23'h7FFFFF, 32'h00FFFF00, lat);
    drop(1);
    cfg_wait = 0;
    check("t2_latency", 64'(lat), 64'd7);
    check("t2_cmd_len", 64'(last_len), 64'd6);
    check("t2_stable", 64'(last_stable), 64'd1);
    check("t2_mem", 64'(mem_rd(23'h7FFFFF)), 64'h00FFFF00);

    // Both clients read continuously: grants alternate starting with c0.
    cfg_lat = 1;
    grant_log.delete();
    fork
      begin
        int l0;
        for (int i = 0; i < 3; i++) client_op(0, 1, 0, 23'(32'h20 + i), '0, l0);
        drop(0);
      end
      begin
        int l1;
        for (int i = 0; i < 3; i++) client_op(1, 1, 0, 23'(32'h30 + i), '0, l1);
        drop(1);
      end
    join
    idle(3);
    check("t3_grant_count", 64'(grant_log.size()), 64'd6);
    check("t3_first", 64'(grant_log[0]), 64'd0);
    for (int i = 1; i < grant_log.size(); i++)
      check($sformatf("t3_alternate_%0d", i), 64'(grant_log[i] != grant_log[i-1]), 64'd1);

    // Back-to-back address advance: exactly one avm_read per address.
    addr_log.delete();
    for (int i = 0; i < 3; i++) client_op(0, 1, 0, 23'(32'h10 + i), '0, lat);
    drop(0);
    idle(10);
    check("t4_read_count", 64'(addr_log.size()), 64'd3);
    for (int i = 0; i < addr_log.size() && i < 3; i++)
      check($sformatf("t4_addr_%0d", i), 64'(addr_log[i]), 64'(32'h10 + i));

    // Load a known value into c0_readdata before the reset test.
    mem[32'h50] = 32'hCAFEF00D;
    client_op(0, 1, 0, 23'h000050, '0, lat);
    drop(0);
    check("t5_pre_rdata", 64'(c0_readdata), 64'hCAFEF00D);

    // Reset during RWAIT: no finished, late readdatavalid ignored.
    sb_en = 0; cfg_lat = 8;
    mem[32'h40] = 32'h55AA55AA;
    fc = fin_cnt;
    req_rd[0] = 1; req_addr[0] = 23'h000040;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t5_avm_read", 64'(avm_read), 64'd0);
    check("t5_avm_write", 64'(avm_write), 64'd0);
    drop(0);
    idle(1);
    rst = 1'b0;
    last_g = 1;
    idle(15);
    check("t5_no_finished", 64'(fin_cnt - fc), 64'd0);
    check("t5_rdata_cleared", 64'(c0_readdata), 64'd0);

    // Refill c0_readdata, then a read against a stuck waitrequest.
    sb_en = 1; cfg_lat = 1;
    client_op(0, 1, 0, 23'h000050, '0, lat);
    drop(0);
    check("t6_pre_rdata", 64'(c0_readdata), 64'hCAFEF00D);
    sb_en = 0; cfg_stuck = 1;
    req_rd[0] = 1; req_addr[0] = 23'h000051;
    start = cyc;
    got   = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (c0_finished) got = 1;
    end
`ifdef SDRAM_RESP_TIMEOUT_EN
    check("t6_fin_seen", 64'(got), 64'd1);
    check("t6_latency", 64'(cyc - start), 64'd17);
    check("t6_rdata_zero", 64'(c0_readdata), 64'd0);
    check("t6_timeout", 64'(o_timeout), 64'd1);
    idle(3);
    check("t6_timeout_sticky", 64'(o_timeout), 64'd1);
`else
    check("t6_no_finished", 64'(got), 64'd0);
    check("t6_timeout_low", 64'(o_timeout), 64'd0);
    check("t6_read_held", 64'(avm_read), 64'd1);
`endif
    drop(0);
    cfg_stuck = 0;
    do_reset();

    // Randomized two-client traffic against the reference model.
    sb_en = 1; cfg_rand = 1;
    fork
      begin
        int l0, gap, op;
        for (int i = 0; i < 40; i++) begin
          op = int'($urandom_range(2, 0));
          client_op(0, op != 1, op != 0, 23'($urandom_range(15, 0)), $urandom(), l0);
          gap = int'($urandom_range(2, 0));
          if (gap > 0) begin drop(0); idle(gap); end
        end
        drop(0);
      end
      begin
        int l1, gap, op;
        for (int i = 0; i < 40; i++) begin
          op = int'($urandom_range(2, 0));
          client_op(1, op != 1, op != 0, 23'($urandom_range(15, 0)), $urandom(), l1);
          gap = int'($urandom_range(2, 0));
          if (gap > 0) begin drop(1); idle(gap); end
        end
        drop(1);
      end
    join
    idle(10);
    check("rand_all_completed", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
